urp_pcie_tlp_serializer: RTL

//  Downstream stage of the PCIe TX arbiter. Takes one arbitrated DATA_SIZE-bit
//  TLP per valid/ready handshake and emits it as BEAT_W-bit beats, marked with

---
 rtl/urp_pcie_tlp_serializer_if.sv | 45 ++++
 rtl/urp_pcie_tlp_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/urp_pcie_tlp_serializer_if.sv
// Bundle of the TLP handshake, beat output and credit signals of the
// PCIe TLP serializer. The optional parity wire exists only when
// URP_PCIE_SER_PARITY_EN is defined.
// master: arbiter/link-layer side. slave: the serializer itself.
interface urp_pcie_tlp_serializer_if #(
  parameter int unsigned DATA_SIZE = 224,
  parameter int unsigned BEAT_W    = 32,
  parameter int unsigned CREDIT_W  = 4
);
  logic                 src_valid_i;
  logic                 src_ready_o;
  logic [DATA_SIZE-1:0] src_data_i;
  logic                 dst_valid_o;
  logic                 dst_ready_i;
  logic [BEAT_W-1:0]    dst_data_o;
  logic                 dst_sop_o;
  logic                 dst_eop_o;
  logic                 credit_ret_i;
  logic [CREDIT_W-1:0]  credit_cnt_o;
`ifdef URP_PCIE_SER_PARITY_EN
  logic                 dst_par_o;

  modport master (
    output src_valid_i, src_data_i, dst_ready_i, credit_ret_i,
    input  src_ready_o, dst_valid_o, dst_data_o, dst_sop_o, dst_eop_o,
           credit_cnt_o, dst_par_o
  );
  modport slave (
    input  src_valid_i, src_data_i, dst_ready_i, credit_ret_i,
    output src_ready_o, dst_valid_o, dst_data_o, dst_sop_o, dst_eop_o,
           credit_cnt_o, dst_par_o
  );
`else
  modport master (
    output src_valid_i, src_data_i, dst_ready_i, credit_ret_i,
    input  src_ready_o, dst_valid_o, dst_data_o, dst_sop_o, dst_eop_o,
           credit_cnt_o
  );
  modport slave (
    input  src_valid_i, src_data_i, dst_ready_i, credit_ret_i,
    output src_ready_o, dst_valid_o, dst_data_o, dst_sop_o, dst_eop_o,
           credit_cnt_o
  );
`endif
endinterface

// File: rtl/urp_pcie_tlp_serializer.sv
// PCIe TLP serializer: accepts one DATA_SIZE-bit TLP per handshake (only
// while a link-partner credit is available) and emits it LSB-first as
// BEAT_W-bit beats with sop/eop marking.
// Optional feature macro: URP_PCIE_SER_PARITY_EN (adds even parity per beat).
module urp_pcie_tlp_serializer #(
  parameter int unsigned DATA_SIZE    = 224,
  parameter int unsigned BEAT_W       = 32,
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned INIT_CREDITS = 4
) (
  input logic clk,
  input logic rst,
  urp_pcie_tlp_serializer_if.slave bus
);
  localparam int unsigned N_BEATS = DATA_SIZE / BEAT_W;
  localparam int unsigned IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_BEATS - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(INIT_CREDITS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic                 src_ready_q, src_ready_d;
  logic                 dst_valid_q, dst_valid_d;
  logic [BEAT_W-1:0]    dst_data_q, dst_data_d;
  logic                 dst_sop_q, dst_sop_d;
  logic                 dst_eop_q, dst_eop_d;
  logic                 accept;
  logic                 beat_done;
`ifdef URP_PCIE_SER_PARITY_EN
  logic                 dst_par_q, dst_par_d;
`endif

  // Next-state logic; every output is derived from the next state so that the
  // registered outputs already match the beat held in the flops.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    data_d     = data_q;
    credit_d   = credit_q;
    accept     = (state_q == IDLE) && bus.src_valid_i && src_ready_q;
    beat_done  = (state_q == SEND) && dst_valid_q && bus.dst_ready_i;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d     = bus.src_data_i;
          beat_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (beat_done) begin
          if (beat_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A return coinciding with an accept cancels out; returns saturate.
    if (accept && !bus.credit_ret_i) begin
      credit_d = credit_q - 1'b1;
    end else if (!accept && bus.credit_ret_i && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + 1'b1;
    end

    src_ready_d = (state_d == IDLE) && (credit_d != '0);
    dst_valid_d = (state_d == SEND);
    dst_data_d  = (state_d == SEND) ? data_d[32'(beat_idx_d) * BEAT_W +: BEAT_W] : '0;
    dst_sop_d   = (state_d == SEND) && (beat_idx_d == '0);
    dst_eop_d   = (state_d == SEND) && (beat_idx_d == LAST_IDX);
`ifdef URP_PCIE_SER_PARITY_EN
    dst_par_d   = ^dst_data_d;
`endif
  end

  // State and output registers; async reset drops any partial TLP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      data_q      <= '0;
      credit_q    <= CREDIT_RST;
      src_ready_q <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      dst_sop_q   <= 1'b0;
      dst_eop_q   <= 1'b0;
`ifdef URP_PCIE_SER_PARITY_EN
      dst_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      data_q      <= data_d;
      credit_q    <= credit_d;
      src_ready_q <= src_ready_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
      dst_sop_q   <= dst_sop_d;
      dst_eop_q   <= dst_eop_d;
`ifdef URP_PCIE_SER_PARITY_EN
      dst_par_q   <= dst_par_d;
`endif
    end
  end

  assign bus.src_ready_o  = src_ready_q;
  assign bus.dst_valid_o  = dst_valid_q;
  assign bus.dst_data_o   = dst_data_q;
  assign bus.dst_sop_o    = dst_sop_q;
  assign bus.dst_eop_o    = dst_eop_q;
  assign bus.credit_cnt_o = credit_q;
`ifdef URP_PCIE_SER_PARITY_EN
  assign bus.dst_par_o    = dst_par_q;
`endif
endmodule
